// File: rtl/mont_cmd_pkg.sv
// Shared definitions for the Montgomery command responder: opcodes,
// command-word field positions and the sequencer state encoding.
package mont_cmd_pkg;

  localparam logic [3:0] OP_LOAD_AB = 4'h1;
  localparam logic [3:0] OP_LOAD_M  = 4'h2;
  localparam logic [3:0] OP_MULT    = 4'h3;
  localparam logic [3:0] OP_STORE   = 4'h4;

  localparam int CMD_OP_LSB  = 0;
  localparam int CMD_OP_MSB  = 3;
  localparam int CMD_SEL_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DIN,
    ST_START,
    ST_WAIT_CORE,
    ST_STORE,
    ST_ACK
  } state_e;

endpackage

// File: rtl/mont_cmd_responder.sv
// Command sequencer between the port1/port2 handshake, the BRAM buses and one
// Montgomery core. Define MONT_CMD_TIMEOUT_EN to add the core watchdog.
module mont_cmd_responder
  import mont_cmd_pkg::*;
#(
  parameter int DATA_W         = 512,
  parameter int CMD_W          = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  port1_din,
  input  logic              port1_valid,
  output logic              port1_read,
  input  logic [DATA_W-1:0] bram_din1,
  input  logic [DATA_W-1:0] bram_din2,
  input  logic              bram_din_valid,
  output logic [DATA_W-1:0] bram_dout1,
  output logic [DATA_W-1:0] bram_dout2,
  output logic              bram_dout1_valid,
  output logic              bram_dout2_valid,
  input  logic              bram_dout_read,
  output logic              port2_valid,
  input  logic              port2_read,
  output logic              core_start,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  output logic [DATA_W-1:0] core_m,
  input  logic [DATA_W-1:0] core_result,
  input  logic              core_done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, m_q, m_d, r_q, r_d;
  logic [DATA_W-1:0] dout1_q, dout1_d, dout2_q, dout2_d;
  logic              err_q, err_d;
  logic              timeout;

  logic [3:0] cmd_op;
  logic       cmd_sel;
  assign cmd_op  = port1_din[CMD_OP_MSB:CMD_OP_LSB];
  assign cmd_sel = port1_din[CMD_SEL_BIT];

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^port1_din[CMD_W-1:CMD_SEL_BIT+1];

`ifdef MONT_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zeroed while in START so every WAIT_CORE visit starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_START)          cnt_d = '0;
    else if (state_q == ST_WAIT_CORE) cnt_d = cnt_q + 1'b1;
  end

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves a latch.
    state_d          = state_q;
    op_d             = op_q;
    sel_d            = sel_q;
    a_d              = a_q;
    b_d              = b_q;
    m_d              = m_q;
    r_d              = r_q;
    dout1_d          = dout1_q;
    dout2_d          = dout2_q;
    err_d            = err_q;
    port1_read       = 1'b0;
    core_start       = 1'b0;
    port2_valid      = 1'b0;
    bram_dout1_valid = 1'b0;
    bram_dout2_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (port1_valid && !rst) begin
          port1_read = 1'b1;
          op_d       = cmd_op;
          sel_d      = cmd_sel;
          case (cmd_op)
            OP_LOAD_AB, OP_LOAD_M: state_d = ST_WAIT_DIN;
            OP_MULT:               state_d = ST_START;
            OP_STORE: begin
              // The selected bus is loaded once; it then holds after valid drops.
              if (cmd_sel) dout2_d = r_q;
              else         dout1_d = r_q;
              state_d = ST_STORE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_ACK;
            end
          endcase
        end
      end
      ST_WAIT_DIN: begin
        if (bram_din_valid) begin
          if (op_q == OP_LOAD_AB) begin
            a_d = bram_din1;
            b_d = bram_din2;
          end else begin
            m_d = bram_din1;
          end
          state_d = ST_ACK;
        end
      end
      ST_START: begin
        core_start = 1'b1;
        state_d    = ST_WAIT_CORE;
      end
      ST_WAIT_CORE: begin
        if (core_done) begin
          r_d     = core_result;
          state_d = ST_ACK;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_STORE: begin
        bram_dout1_valid = !sel_q;
        bram_dout2_valid = sel_q;
        if (bram_dout_read) state_d = ST_ACK;
      end
      ST_ACK: begin
        port2_valid = 1'b1;
        if (port2_read) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the wide operand/result registers are reset too, because their
      // contents are directly visible on core_* and bram_dout* after reset.
      state_q <= ST_IDLE;
      op_q    <= '0;
      sel_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      dout1_q <= '0;
      dout2_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same edge.
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      r_q     <= r_d;
      dout1_q <= dout1_d;
      dout2_q <= dout2_d;
      err_q   <= err_d;
    end
  end

  assign core_a     = a_q;
  assign core_b     = b_q;
  assign core_m     = m_q;
  assign bram_dout1 = dout1_q;
  assign bram_dout2 = dout2_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mont_cmd_responder.sv
// Self-checking bench for mont_cmd_responder: a per-command timeline model
// predicts every output each cycle; a few literal checks pin the model.
module tb_mont_cmd_responder;
  import mont_cmd_pkg::*;

  localparam int DW  = 512;
  localparam int CW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] port1_din = '0;
  logic          port1_valid = 1'b0;
  logic          port1_read;
  logic [DW-1:0] bram_din1 = '0, bram_din2 = '0;
  logic          bram_din_valid = 1'b0;
  logic [DW-1:0] bram_dout1, bram_dout2;
  logic          bram_dout1_valid, bram_dout2_valid;
  logic          bram_dout_read = 1'b0;
  logic          port2_valid;
  logic          port2_read = 1'b0;
  logic          core_start;
  logic [DW-1:0] core_a, core_b, core_m;
  logic [DW-1:0] core_result = '0;
  logic          core_done = 1'b0;
  logic          err;

  mont_cmd_responder #(.DATA_W(DW), .CMD_W(CW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .port1_din(port1_din), .port1_valid(port1_valid), .port1_read(port1_read),
    .bram_din1(bram_din1), .bram_din2(bram_din2), .bram_din_valid(bram_din_valid),
    .bram_dout1(bram_dout1), .bram_dout2(bram_dout2),
    .bram_dout1_valid(bram_dout1_valid), .bram_dout2_valid(bram_dout2_valid),
    .bram_dout_read(bram_dout_read),
    .port2_valid(port2_valid), .port2_read(port2_read),
    .core_start(core_start), .core_a(core_a), .core_b(core_b), .core_m(core_m),
    .core_result(core_result), .core_done(core_done), .err(err)
  );

  always #5 clk = ~clk;

  // Architectural model and per-cycle expected handshake outputs.
  logic [DW-1:0] mdl_a, mdl_b, mdl_m, mdl_r, mdl_dout1, mdl_dout2;
  logic          mdl_err;
  logic          exp_p1r, exp_p2, exp_start, exp_v1, exp_v2;
  bit            chk_en = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;
  int            pend = 0;
  logic [DW-1:0] pend_x, pend_y;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    mdl_a = '0; mdl_b = '0; mdl_m = '0; mdl_r = '0;
    mdl_dout1 = '0; mdl_dout2 = '0; mdl_err = 1'b0; pend = 0;
  endtask

  always begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      check("port1_read", port1_read, exp_p1r);
      check("port2_valid", port2_valid, exp_p2);
      check("core_start", core_start, exp_start);
      check("dout1_valid", bram_dout1_valid, exp_v1);
      check("dout2_valid", bram_dout2_valid, exp_v2);
      check("err", err, mdl_err);
      check("core_a", core_a, mdl_a);
      check("core_b", core_b, mdl_b);
      check("core_m", core_m, mdl_m);
      check("bram_dout1", bram_dout1, mdl_dout1);
      check("bram_dout2", bram_dout2, mdl_dout2);
    end
  end

  // Start a new cycle: everything quiet, data buses carry junk.
  task automatic next();
    @(negedge clk);
    {exp_p1r, exp_p2, exp_start, exp_v1, exp_v2} = '0;
    port1_valid = 1'b0; port2_read = 1'b0; bram_din_valid = 1'b0;
    core_done = 1'b0; bram_dout_read = 1'b0;
    port1_din = $urandom;
    bram_din1 = rnd_word(); bram_din2 = rnd_word(); core_result = rnd_word();
  endtask

  // Random strobes on inputs that must be ignored in the current cycle.
  task automatic spur(input bit p1, input bit din, input bit done, input bit dread, input bit p2r);
    if (p1)    port1_valid    = ($urandom_range(3) == 0);
    if (din)   bram_din_valid = ($urandom_range(3) == 0);
    if (done)  core_done      = ($urandom_range(3) == 0);
    if (dread) bram_dout_read = ($urandom_range(3) == 0);
    if (p2r)   port2_read     = ($urandom_range(3) == 0);
  endtask

  task automatic apply_pending();
    case (pend)
      1: begin mdl_a = pend_x; mdl_b = pend_y; end
      2: mdl_m = pend_x;
      3: mdl_r = pend_x;
      4: mdl_err = 1'b1;
      default: ;
    endcase
    pend = 0;
  endtask

  task automatic accept(input logic [31:0] cmd);
    next();
    spur(0, 1, 1, 1, 1);
    port1_valid = 1'b1;
    port1_din   = cmd;
    exp_p1r     = 1'b1;
  endtask

  task automatic ack_phase(input int hold);
    for (int i = 0; i <= hold; i++) begin
      next();
      if (i == 0) apply_pending();
      spur(1, 1, 1, 1, 0);
      exp_p2 = 1'b1;
      if (i == hold) port2_read = 1'b1;
    end
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      next();
      spur(0, 1, 1, 1, 1);
    end
  endtask

  task automatic cmd_load(input bit ab, input int dly, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input int hold);
    logic [31:0] c;
    c = $urandom;
    c[3:0] = ab ? OP_LOAD_AB : OP_LOAD_M;
    accept(c);
    for (int i = 0; i < dly; i++) begin
      next();
      spur(1, 0, 1, 1, 1);
    end
    next();
    spur(1, 0, 1, 1, 1);
    bram_din_valid = 1'b1;
    bram_din1 = d1;
    bram_din2 = d2;
    pend = ab ? 1 : 2; pend_x = d1; pend_y = d2;
    ack_phase(hold);
  endtask

  task automatic cmd_mult(input int lat, input logic [DW-1:0] res, input int hold);
    logic [31:0] c;
    c = $urandom;
    c[3:0] = OP_MULT;
    accept(c);
    next();
    spur(1, 1, 1, 1, 1);
    exp_start = 1'b1;
    for (int i = 0; i < lat - 1; i++) begin
      next();
      spur(1, 1, 0, 1, 1);
    end
    next();
    spur(1, 1, 0, 1, 1);
    core_done = 1'b1;
    core_result = res;
    pend = 3; pend_x = res;
    ack_phase(hold);
  endtask

  task automatic cmd_store(input bit sel, input int hold, input int ack_hold);
    logic [31:0] c;
    c = $urandom;
    c[3:0] = OP_STORE;
    c[4] = sel;
    accept(c);
    for (int i = 0; i <= hold; i++) begin
      next();
      if (i == 0) begin
        if (sel) mdl_dout2 = mdl_r;
        else     mdl_dout1 = mdl_r;
      end
      spur(1, 1, 1, 0, 1);
      exp_v1 = !sel;
      exp_v2 = sel;
      if (i == hold) bram_dout_read = 1'b1;
    end
    ack_phase(ack_hold);
  endtask

  task automatic cmd_nop(input logic [3:0] op, input int hold);
    logic [31:0] c;
    c = $urandom;
    c[3:0] = op;
    accept(c);
    pend = 4;
    ack_phase(hold);
  endtask

  logic [DW-1:0] pat_a, pat_b;

  initial begin
    model_reset();
    {exp_p1r, exp_p2, exp_start, exp_v1, exp_v2} = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // LOAD_AB with din_valid arriving 3 cycles late.
    pat_a = {16{32'hAAAA_AAAA}};
    pat_b = {16{32'h5555_5555}};
    cmd_load(1'b1, 3, pat_a, pat_b, 2);
    check("lit_core_a", core_a, {16{32'hAAAA_AAAA}});
    check("lit_core_b", core_b, {16{32'h5555_5555}});
    idle_gap(1);

    // LOAD_M, then MULT with a 10-cycle core, then STORE to bus 2 held 5 cycles.
    cmd_load(1'b0, 0, rnd_word(), rnd_word(), 0);
    cmd_mult(10, 512'h1234, 1);
    cmd_store(1'b1, 4, 0);
    check("lit_dout2", bram_dout2, 512'h1234);
    check("lit_dout1", bram_dout1, 512'h0);

    // Illegal opcode raises the sticky error.
    cmd_nop(4'hF, 1);
    check("lit_err", err, 1'b1);

    // Reset in the middle of WAIT_CORE, then a stale core_done.
    accept({28'h0, OP_MULT});
    next(); spur(1, 1, 1, 1, 1); exp_start = 1'b1;
    for (int i = 0; i < 3; i++) begin next(); spur(1, 1, 0, 1, 1); end
    next(); rst = 1'b1; chk_en = 1'b0;
    next(); rst = 1'b0; model_reset(); chk_en = 1'b1;
    #3;
    check("lit_rst_err", err, 1'b0);
    check("lit_rst_dout2", bram_dout2, 512'h0);
    next(); core_done = 1'b1; core_result = rnd_word();
    idle_gap(2);
    cmd_load(1'b1, 1, rnd_word(), rnd_word(), 0);
    cmd_store(1'b0, 2, 0);
    check("lit_r_after_rst", bram_dout1, 512'h0);

`ifdef MONT_CMD_TIMEOUT_EN
    // Watchdog: no core_done, expect ACK 17 cycles after the start pulse.
    cmd_mult(3, 512'hBEEF, 0);
    accept({28'h0, OP_MULT});
    next(); spur(1, 1, 1, 1, 1); exp_start = 1'b1;
    for (int i = 0; i < TMO; i++) begin next(); spur(1, 1, 0, 1, 1); end
    pend = 4;
    ack_phase(1);
    cmd_store(1'b0, 0, 0);
    check("lit_tmo_r", bram_dout1, 512'hBEEF);
`endif

    // Randomized command stream.
    for (int n = 0; n < 40; n++) begin
      int k;
      logic [3:0] op;
      k = $urandom_range(8);
      case (k)
        0, 1: cmd_load(1'b1, $urandom_range(3), rnd_word(), rnd_word(), $urandom_range(2));
        2:    cmd_load(1'b0, $urandom_range(3), rnd_word(), rnd_word(), $urandom_range(2));
        3, 4: cmd_mult($urandom_range(12, 1), rnd_word(), $urandom_range(2));
        5, 6, 7: cmd_store($urandom_range(1), $urandom_range(4), $urandom_range(2));
        default: begin
          op = 4'($urandom_range(15));
          if (op >= 4'h1 && op <= 4'h4) op = 4'h0;
          cmd_nop(op, $urandom_range(2));
        end
      endcase
      idle_gap($urandom_range(2));
    end

    idle_gap(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
